// File: rtl/qr_pkg.sv
// Shared constants and types for the QR finder-pattern scan path.
package qr_pkg;

  localparam int LINE_WIDTH = 480;
  localparam int IDX_BITS   = $clog2(LINE_WIDTH);
  localparam int ARITH_BITS = 13;
  localparam int RUNS       = 5;

  localparam logic PIX_DARK = 1'b0;

  localparam int RATIO_SIDE_LO = 1;
  localparam int RATIO_SIDE_HI = 3;
  localparam int RATIO_CTR_LO  = 5;
  localparam int RATIO_CTR_HI  = 7;
  localparam int RATIO_SCALE   = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/finder_ratio_check.sv
// Combinational 1:1:3:1:1 test on five run lengths (index 0 = oldest run).
module finder_ratio_check
  import qr_pkg::*;
(
  input  logic [RUNS-1:0][IDX_BITS-1:0] run_len,
  output logic                          pass,
  output logic [ARITH_BITS-1:0]         total
);

  localparam logic [ARITH_BITS-1:0] K_SCALE   = ARITH_BITS'(RATIO_SCALE);
  localparam logic [ARITH_BITS-1:0] K_SIDE_LO = ARITH_BITS'(RATIO_SIDE_LO);
  localparam logic [ARITH_BITS-1:0] K_SIDE_HI = ARITH_BITS'(RATIO_SIDE_HI);
  localparam logic [ARITH_BITS-1:0] K_CTR_LO  = ARITH_BITS'(RATIO_CTR_LO);
  localparam logic [ARITH_BITS-1:0] K_CTR_HI  = ARITH_BITS'(RATIO_CTR_HI);

  // Each run r is compared as 14*r against k*T, so no divider is needed.
  always_comb begin
    logic [ARITH_BITS-1:0] scaled;
    total  = '0;
    pass   = 1'b1;
    scaled = '0;
    for (int i = 0; i < RUNS; i++) begin
      total = total + ARITH_BITS'(run_len[i]);
    end
    for (int i = 0; i < RUNS; i++) begin
      scaled = ARITH_BITS'(run_len[i]) * K_SCALE;
      if (i == 2) begin
        if (scaled < K_CTR_LO * total || scaled > K_CTR_HI * total) pass = 1'b0;
      end else begin
        if (scaled < K_SIDE_LO * total || scaled > K_SIDE_HI * total) pass = 1'b0;
      end
    end
  end

endmodule

// File: rtl/finder_run_scanner.sv
// Walks one cleaned scan line a pixel per clock, tracks run lengths and
// reports every dark/light/dark/light/dark crossing in 1:1:3:1:1 ratio.
module finder_run_scanner
  import qr_pkg::*;
#(
  parameter int WIDTH    = LINE_WIDTH,
  parameter int CNT_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [WIDTH-1:0]    pattern_in,
  input  logic                start_in,
  output logic                busy_out,
  output logic                hit_valid,
  output logic [IDX_BITS-1:0] hit_center,
  output logic [IDX_BITS-1:0] hit_width,
  output logic [CNT_BITS-1:0] hit_count,
  output logic                done_out,
  output scan_state_t         state_dbg
);

  localparam logic [2:0]          RUN_CNT_MAX = 3'd5;
  localparam logic [IDX_BITS-1:0] LAST_IDX    = IDX_BITS'(WIDTH - 1);
  localparam logic [IDX_BITS-1:0] ONE         = IDX_BITS'(1);

  scan_state_t           state;
  logic [WIDTH-1:0]      line_q;
  logic [IDX_BITS-1:0]   idx;
  logic                  cur_colour;
  logic [IDX_BITS-1:0]   cur_start;
  logic [IDX_BITS-1:0]   cur_len;
  logic [IDX_BITS-1:0]   hist_len   [RUNS];
  logic [IDX_BITS-1:0]   hist_start [RUNS];
  logic [2:0]            run_cnt;

  logic                          pix;
  logic                          closing;
  logic                          hit_fire;
  logic                          ratio_pass;
  logic [ARITH_BITS-1:0]         ratio_total;
  logic [RUNS-1:0][IDX_BITS-1:0] win_len;
  logic [IDX_BITS-1:0]           win_center;

  assign state_dbg = state;
  assign pix       = line_q[idx];

  // The run being closed is the newest of the five; hist[1..4] are the older four.
  always_comb begin
    for (int i = 0; i < RUNS - 1; i++) win_len[i] = hist_len[i+1];
    win_len[RUNS-1] = cur_len;
    win_center = hist_start[3] + (hist_len[3] >> 1);
    closing    = (state == ST_FLUSH) ||
                 (state == ST_SCAN && idx != '0 && pix != cur_colour);
    hit_fire   = closing && (cur_colour == PIX_DARK) &&
                 (run_cnt >= 3'd4) && ratio_pass;
  end

  finder_ratio_check u_ratio (
    .run_len (win_len),
    .pass    (ratio_pass),
    .total   (ratio_total)
  );

  // start_in is a single-cycle pulse honoured only in IDLE; hits have no
  // back-pressure, so hit_valid is a one-cycle strobe the consumer must take.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= ST_IDLE;
      line_q     <= '0;
      idx        <= '0;
      cur_colour <= 1'b0;
      cur_start  <= '0;
      cur_len    <= '0;
      run_cnt    <= '0;
      for (int i = 0; i < RUNS; i++) begin
        hist_len[i]   <= '0;
        hist_start[i] <= '0;
      end
      busy_out   <= 1'b0;
      hit_valid  <= 1'b0;
      hit_center <= '0;
      hit_width  <= '0;
      hit_count  <= '0;
      done_out   <= 1'b0;
    end else begin
      hit_valid <= 1'b0;
      done_out  <= 1'b0;

      if (hit_fire) begin
        hit_valid  <= 1'b1;
        hit_center <= win_center;
        hit_width  <= ratio_total[IDX_BITS-1:0];
        if (hit_count != {CNT_BITS{1'b1}}) hit_count <= hit_count + 1'b1;
      end

      if (closing) begin
        for (int i = 0; i < RUNS - 1; i++) begin
          hist_len[i]   <= hist_len[i+1];
          hist_start[i] <= hist_start[i+1];
        end
        hist_len[RUNS-1]   <= cur_len;
        hist_start[RUNS-1] <= cur_start;
        if (run_cnt != RUN_CNT_MAX) run_cnt <= run_cnt + 3'd1;
      end

      case (state)
        ST_IDLE: begin
          if (start_in) begin
            line_q     <= pattern_in;
            idx        <= '0;
            cur_colour <= 1'b0;
            cur_start  <= '0;
            cur_len    <= '0;
            run_cnt    <= '0;
            for (int i = 0; i < RUNS; i++) begin
              hist_len[i]   <= '0;
              hist_start[i] <= '0;
            end
            hit_count  <= '0;
            busy_out   <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (idx == '0 || pix != cur_colour) begin
            cur_colour <= pix;
            cur_start  <= idx;
            cur_len    <= ONE;
          end else begin
            cur_len <= cur_len + ONE;
          end
          if (idx == LAST_IDX) state <= ST_FLUSH;
          else                 idx   <= idx + ONE;
        end
        ST_FLUSH: begin
          busy_out <= 1'b0;
          done_out <= 1'b1;
          state    <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_finder_run_scanner.sv
// Directed bench for finder_run_scanner: vector table plus reset/restart sequence.
module tb_finder_run_scanner;
  import qr_pkg::*;

  localparam int W        = LINE_WIDTH;
  localparam int DONE_CYC = W + 2;
  localparam int TIMEOUT  = 700;

  // clock / reset block
  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          start_in = 1'b0;
  logic [W-1:0]  pattern_in = '1;
  logic          busy_out, hit_valid, done_out;
  logic [8:0]    hit_center, hit_width;
  logic [7:0]    hit_count;
  scan_state_t   state_dbg;

  always #5 clk_in = ~clk_in;

  finder_run_scanner #(.WIDTH(W), .CNT_BITS(8)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .pattern_in (pattern_in),
    .start_in   (start_in),
    .busy_out   (busy_out),
    .hit_valid  (hit_valid),
    .hit_center (hit_center),
    .hit_width  (hit_width),
    .hit_count  (hit_count),
    .done_out   (done_out),
    .state_dbg  (state_dbg)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: hit = {cycle[9:0], center[8:0], width[8:0]}
  logic [27:0] exp_q[$];
  logic [27:0] obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cyc, count_at_done, center_at_done, width_at_done, busy_errs;

  typedef struct {
    logic [W-1:0] pat;
    int           n_hits;
    int           hit_cyc;
    int           center;
    int           width;
    int           count;
    int           last_center;
    int           last_width;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [W-1:0] finder_line(input int base, input int a, input int b,
                                               input int c, input int d, input int e);
    logic [W-1:0] p;
    p = '1;
    for (int i = base; i < base + a; i++) p[i] = PIX_DARK;
    for (int i = base + a + b; i < base + a + b + c; i++) p[i] = PIX_DARK;
    for (int i = base + a + b + c + d; i < base + a + b + c + d + e; i++) p[i] = PIX_DARK;
    return p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // driver: pulse start in cycle 0, then observe cycles 1.. until done_out.
  // extra_start > 0 pulses a (to be ignored) start in that cycle; abort_at > 0 stops early.
  task automatic run_line(input logic [W-1:0] pat, input int extra_start, input int abort_at);
    obs_q.delete();
    done_cyc = -1; count_at_done = -1; center_at_done = -1; width_at_done = -1;
    busy_errs = 0;
    @(negedge clk_in);
    pattern_in = pat;
    start_in   = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      if (hit_valid) obs_q.push_back({10'(c), hit_center, hit_width});
      if (busy_out != (c < DONE_CYC)) busy_errs++;
      if (done_out) begin
        done_cyc       = c;
        count_at_done  = int'(hit_count);
        center_at_done = int'(hit_center);
        width_at_done  = int'(hit_width);
        break;
      end
      if (c == abort_at) break;
      if (c == extra_start) begin
        start_in   = 1'b1;
        pattern_in = '1;
      end
    end
    start_in = 1'b0;
  endtask

  task automatic compare_hits(input string tag);
    logic [27:0] e, o;
    check({tag, "_nhits"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_hit_cycle"},  int'(o[27:18]), int'(e[27:18]));
      check({tag, "_hit_center"}, int'(o[17:9]),  int'(e[17:9]));
      check({tag, "_hit_width"},  int'(o[8:0]),   int'(e[8:0]));
    end
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs"},
          int'({busy_out, hit_valid, done_out, hit_center, hit_width, hit_count}), 0);
    check({tag, "_state"}, int'(state_dbg), int'(ST_IDLE));
  endtask

  initial begin
    vecs[0] = '{finder_line(100, 4, 4, 12, 4, 4), 1, 130, 114, 28, 1, 114, 28};
    vecs[1] = '{{W{1'b1}},                         0,   0,   0,  0, 0, 114, 28};
    vecs[2] = '{finder_line(452, 4, 4, 12, 4, 4), 1, 482, 466, 28, 1, 466, 28};
    vecs[3] = '{finder_line(50, 4, 4, 4, 4, 4),   0,   0,   0,  0, 0, 466, 28};
    vecs[4] = '{finder_line(10, 2, 2, 6, 2, 2),   1,  26,  17, 14, 1,  17, 14};

    repeat (3) @(negedge clk_in);
    check_all_zero("por");
    rst_in = 1'b1;

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      if (vecs[v].n_hits > 0)
        exp_q.push_back({10'(vecs[v].hit_cyc), 9'(vecs[v].center), 9'(vecs[v].width)});
      run_line(vecs[v].pat, 0, 0);
      check({tag, "_done_cycle"},  done_cyc, DONE_CYC);
      check({tag, "_hit_count"},   count_at_done, vecs[v].count);
      check({tag, "_held_center"}, center_at_done, vecs[v].last_center);
      check({tag, "_held_width"},  width_at_done, vecs[v].last_width);
      check({tag, "_busy_errs"},   busy_errs, 0);
      compare_hits(tag);
    end

    // reset in cycle 200 of a scan, then rescan with a stray start in cycle 300
    exp_q.push_back({10'd130, 9'd114, 9'd28});
    run_line(vecs[0].pat, 0, 200);
    compare_hits("abort_pre");
    rst_in = 1'b0;
    #1;
    check_all_zero("abort_rst");
    repeat (3) @(negedge clk_in);
    check_all_zero("abort_rst_hold");
    rst_in = 1'b1;

    exp_q.push_back({10'd26, 9'd17, 9'd14});
    run_line(vecs[4].pat, 300, 0);
    check("restart_done_cycle", done_cyc, DONE_CYC);
    check("restart_hit_count",  count_at_done, 1);
    check("restart_center",     center_at_done, 17);
    check("restart_busy_errs",  busy_errs, 0);
    compare_hits("restart");

    @(negedge clk_in);
    @(negedge clk_in);
    check("post_idle_state", int'(state_dbg), int'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
